// File: rtl/phase_slot_mult_arbiter_if.sv
// Requester-side bus of the shared multiplier arbiter.
// Master drives requests/operands, slave returns grants and products.
interface phase_slot_mult_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 18
);
    logic [3:0]              clk_phase;
    logic                    stall;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] a_in;
    logic [N_REQ*DATA_W-1:0] b_in;
    logic [N_REQ-1:0]        grant;
    logic [2*DATA_W-1:0]     prod_out;
    logic                    prod_valid;
    logic [1:0]              prod_id;
    logic [N_REQ-1:0]        overrun;

    modport master (
        output clk_phase, stall, req, a_in, b_in,
        input  grant, prod_out, prod_valid, prod_id, overrun
    );

    modport slave (
        input  clk_phase, stall, req, a_in, b_in,
        output grant, prod_out, prod_valid, prod_id, overrun
    );
endinterface

// File: rtl/phase_slot_mult_arbiter.sv
// Phase-slot / round-robin arbiter sharing one signed multiplier,
// two-stage product pipeline and per-requester starvation monitor.
module phase_slot_mult_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 18
) (
    input  logic                       sys_clk,
    input  logic                       reset,
    phase_slot_mult_arbiter_if.slave   bus
);
    localparam int PW = 2 * DATA_W;

    logic [N_REQ-1:0]         grant_q, grant_d, elig;
    logic [1:0]               rr_q, rr_d, win_id, idx;
    logic                     win;
    logic                     s1_v_q;
    logic signed [DATA_W-1:0] s1_a_q, s1_b_q, s1_a_d, s1_b_d;
    logic [1:0]               s1_id_q;
    logic signed [PW-1:0]     prod_q, prod_d;
    logic [1:0]               pid_q;
    logic                     pv_q;
    logic [4:0]               wait_q [N_REQ];
    logic [4:0]               wait_d [N_REQ];
    logic [N_REQ-1:0]         ovr_q, ovr_d;
    logic                     unused_phase_hi;

    assign unused_phase_hi = ^bus.clk_phase[3:2];

    // Slot owner first, then scan upward from rr_q+1 with wrap.
    always_comb begin
        elig   = bus.req & ~grant_q & {N_REQ{~bus.stall}};
        win    = 1'b0;
        win_id = rr_q;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (elig[k] && bus.clk_phase[1:0] == 2'(k)) begin
                win    = 1'b1;
                win_id = 2'(k);
            end
        end
        for (int i = 1; i <= N_REQ; i++) begin
            idx = 2'((int'(rr_q) + i) % N_REQ);
            if (!win && elig[idx]) begin
                win    = 1'b1;
                win_id = idx;
            end
        end
        grant_d = '0;
        if (win)
            grant_d[win_id] = 1'b1;
        rr_d   = win ? win_id : rr_q;
        s1_a_d = bus.a_in[int'(win_id)*DATA_W +: DATA_W];
        s1_b_d = bus.b_in[int'(win_id)*DATA_W +: DATA_W];
        prod_d = PW'(s1_a_q) * PW'(s1_b_q);
    end

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            wait_d[k] = wait_q[k];
            if (!bus.req[k] || (win && win_id == 2'(k)))
                wait_d[k] = '0;
            else if (wait_q[k] != 5'd31)
                wait_d[k] = wait_q[k] + 5'd1;
            ovr_d[k] = ovr_q[k] | (wait_d[k] == 5'd16);
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
            rr_q    <= 2'(N_REQ - 1);
            s1_v_q  <= 1'b0;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            s1_id_q <= '0;
            prod_q  <= '0;
            pid_q   <= '0;
            pv_q    <= 1'b0;
            ovr_q   <= '0;
            for (int k = 0; k < N_REQ; k++)
                wait_q[k] <= '0;
        end else begin
            grant_q <= grant_d;
            rr_q    <= rr_d;
            s1_v_q  <= win;
            if (win) begin
                s1_a_q  <= s1_a_d;
                s1_b_q  <= s1_b_d;
                s1_id_q <= win_id;
            end
            pv_q <= s1_v_q;
            if (s1_v_q) begin
                prod_q <= prod_d;
                pid_q  <= s1_id_q;
            end
            ovr_q <= ovr_d;
            for (int k = 0; k < N_REQ; k++)
                wait_q[k] <= wait_d[k];
        end
    end

    assign bus.grant      = grant_q;
    assign bus.prod_out   = prod_q;
    assign bus.prod_valid = pv_q;
    assign bus.prod_id    = pid_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_phase_slot_mult_arbiter.sv
// Directed bench for phase_slot_mult_arbiter: vector table plus
// hand-written stall, reset and extreme-operand sequences.
module tb_phase_slot_mult_arbiter;
    localparam int N  = 4;
    localparam int DW = 18;
    localparam longint BIG = 64'sd17179869184;

    typedef struct {
        logic [3:0] req;
        logic [3:0] ph;
        logic       st;
        logic [3:0] g;
        logic       pv;
        logic [1:0] id;
        longint     p;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    vec_t tbl [14];

    phase_slot_mult_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    phase_slot_mult_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
        .sys_clk (clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ops(input int k, input int a, input int b);
        bus.a_in[k*DW +: DW] = DW'(a);
        bus.b_in[k*DW +: DW] = DW'(b);
    endtask

    task automatic default_ops();
        set_ops(0, 2, -7);
        set_ops(1, 100, 300);
        set_ops(2, 3, -5);
        set_ops(3, -131072, -131072);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " grant"}, longint'(bus.grant), 0);
        chk({nm, " pv"}, longint'(bus.prod_valid), 0);
        chk({nm, " prod"}, longint'(bus.prod_out), 0);
        chk({nm, " id"}, longint'(bus.prod_id), 0);
        chk({nm, " ovr"}, longint'(bus.overrun), 0);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req       = '0;
        bus.stall     = 1'b0;
        bus.clk_phase = '0;
        @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.req  = '0;
        bus.stall = 1'b0;
        bus.clk_phase = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        default_ops();

        tbl[0]  = '{4'b1010, 4'd0,  1'b0, 4'b0010, 1'b0, 2'd0, 0};
        tbl[1]  = '{4'b1010, 4'd1,  1'b0, 4'b1000, 1'b1, 2'd1, 30000};
        tbl[2]  = '{4'b1010, 4'd2,  1'b0, 4'b0010, 1'b1, 2'd3, BIG};
        tbl[3]  = '{4'b1010, 4'd3,  1'b0, 4'b1000, 1'b1, 2'd1, 30000};
        tbl[4]  = '{4'b1111, 4'd4,  1'b0, 4'b0001, 1'b1, 2'd3, BIG};
        tbl[5]  = '{4'b1111, 4'd5,  1'b0, 4'b0010, 1'b1, 2'd0, -14};
        tbl[6]  = '{4'b1111, 4'd6,  1'b0, 4'b0100, 1'b1, 2'd1, 30000};
        tbl[7]  = '{4'b1111, 4'd7,  1'b0, 4'b1000, 1'b1, 2'd2, -15};
        tbl[8]  = '{4'b1111, 4'd8,  1'b0, 4'b0001, 1'b1, 2'd3, BIG};
        tbl[9]  = '{4'b1111, 4'd9,  1'b1, 4'b0000, 1'b1, 2'd0, -14};
        tbl[10] = '{4'b1111, 4'd10, 1'b1, 4'b0000, 1'b0, 2'd0, 0};
        tbl[11] = '{4'b1111, 4'd11, 1'b0, 4'b1000, 1'b0, 2'd0, 0};
        tbl[12] = '{4'b0000, 4'd12, 1'b0, 4'b0000, 1'b1, 2'd3, BIG};
        tbl[13] = '{4'b0000, 4'd13, 1'b0, 4'b0000, 1'b0, 2'd0, 0};

        repeat (2) @(negedge clk);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            bus.req       = tbl[i].req;
            bus.clk_phase = tbl[i].ph;
            bus.stall     = tbl[i].st;
            tick();
            chk($sformatf("row%0d grant", i), longint'(bus.grant), longint'(tbl[i].g));
            chk($sformatf("row%0d pv", i), longint'(bus.prod_valid), longint'(tbl[i].pv));
            chk($sformatf("row%0d ovr", i), longint'(bus.overrun), 0);
            if (tbl[i].pv) begin
                chk($sformatf("row%0d prod", i), longint'($signed(bus.prod_out)), tbl[i].p);
                chk($sformatf("row%0d id", i), longint'(bus.prod_id), longint'(tbl[i].id));
            end
        end

        // Lone requester: granted every other edge, product two edges later.
        do_reset();
        bus.req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("solo%0d grant", i), longint'(bus.grant),
                (i % 2 == 0) ? 4 : 0);
            chk($sformatf("solo%0d pv", i), longint'(bus.prod_valid),
                (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 1) begin
                chk($sformatf("solo%0d prod", i), longint'($signed(bus.prod_out)), -15);
                chk($sformatf("solo%0d id", i), longint'(bus.prod_id), 2);
            end
        end
        chk("solo ovr", longint'(bus.overrun), 0);

        // Extreme operand corner.
        do_reset();
        set_ops(0, 131071, -131072);
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0000;
        tick();
        chk("ext pv", longint'(bus.prod_valid), 1);
        chk("ext prod", longint'($signed(bus.prod_out)), -64'sd17179738112);
        default_ops();

        // Starvation under stall, sticky overrun.
        do_reset();
        bus.req   = 4'b0001;
        bus.stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("stall%0d grant", i), longint'(bus.grant), 0);
            chk($sformatf("stall%0d ovr", i), longint'(bus.overrun),
                (i >= 16) ? 1 : 0);
        end
        bus.stall = 1'b0;
        tick();
        chk("unstall grant", longint'(bus.grant), 1);
        chk("unstall ovr", longint'(bus.overrun), 1);
        bus.req = 4'b0000;
        tick();
        chk("unstall pv", longint'(bus.prod_valid), 1);
        chk("unstall prod", longint'($signed(bus.prod_out)), -14);
        tick();
        chk("sticky ovr", longint'(bus.overrun), 1);

        // Reset right after a grant discards the in-flight product.
        do_reset();
        bus.req = 4'b0100;
        tick();
        chk("pre-rst grant", longint'(bus.grant), 4);
        reset   = 1'b1;
        bus.req = 4'b1010;
        #1;
        chk_zero("mid-rst");
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("in-rst%0d pv", i), longint'(bus.prod_valid), 0);
        end
        reset = 1'b0;
        tick();
        chk("post-rst grant", longint'(bus.grant), 2);
        chk("post-rst pv", longint'(bus.prod_valid), 0);
        tick();
        chk("post-rst grant2", longint'(bus.grant), 8);
        chk("post-rst pv2", longint'(bus.prod_valid), 1);
        chk("post-rst id", longint'(bus.prod_id), 1);
        chk("post-rst prod", longint'($signed(bus.prod_out)), 30000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
